// File: rtl/cfg_ctrl_pkg.sv
// Shared types and constants for the configuration-chain loader.
package cfg_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StShift,
    StDrain
  } cfg_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNDERRUN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ABORT    = 2'b11;

endpackage

// File: rtl/cfg_word_skid.sv
// One-entry prefetch buffer holding the next host word while the current one shifts out.
module cfg_word_skid #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             crst_n,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             load,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  assign push_ready = ~full_q;
  assign out_valid  = full_q;
  assign out_data   = data_q;

  // Flush beats a push; a push only lands when empty, so it never meets a load.
  always_ff @(posedge clk or negedge crst_n) begin
    if (!crst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (push_valid && !full_q) begin
      full_q <= 1'b1;
      data_q <= push_data;
    end else if (load) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serializes host words MSB first onto the config shift chain and confirms the frame
// marker returns from the chain tail before a timeout.
module cfg_chain_loader
  import cfg_ctrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  crst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic                  abort,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  output logic                  cfg_in_start,
  output logic                  cfg_bit_in,
  input  logic                  cfg_out_start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [TW-1:0]        T_MAX   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]        T_ONE   = TW'(1);
  localparam logic [BW-1:0]        BIT_MAX = BW'(WORD_WIDTH - 1);
  localparam logic [BW-1:0]        BIT_ONE = BW'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  cfg_state_e            state_q;
  logic [WORD_WIDTH-1:0] shreg_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [LEN_WIDTH-1:0]  num_q;
  logic [LEN_WIDTH-1:0]  acc_q;
  logic [TW-1:0]         tcnt_q;
  logic                  flag_q;

  logic                  buf_ready, buf_valid, buf_push, buf_load, buf_flush;
  logic [WORD_WIDTH-1:0] buf_data;
  logic                  in_shift, last_bit, words_left, cap_en, flag_now;

  assign busy       = (state_q != StIdle);
  assign in_shift   = (state_q == StShift);
  assign last_bit   = in_shift && (bit_cnt_q == BIT_MAX);
  assign words_left = (acc_q < num_q);
  assign word_ready = (state_q == StFetch) || (in_shift && buf_ready && words_left);
  // Chain is cleared between loads, so the shift register MSB is the serial output.
  assign cfg_bit_in = shreg_q[WORD_WIDTH-1];

  // The marker's own cycle is excluded; the chain can only echo it afterwards.
  assign cap_en   = (in_shift && !cfg_in_start) || (state_q == StDrain);
  assign flag_now = flag_q || (cap_en && cfg_out_start);

  assign buf_push  = in_shift && word_valid && words_left && !abort;
  assign buf_load  = last_bit && !abort;
  assign buf_flush = (busy && abort) || (last_bit && !buf_valid);

  cfg_word_skid #(
    .WIDTH(WORD_WIDTH)
  ) u_skid (
    .clk       (clk),
    .crst_n    (crst_n),
    .flush     (buf_flush),
    .push_valid(buf_push),
    .push_ready(buf_ready),
    .push_data (word_data),
    .load      (buf_load),
    .out_valid (buf_valid),
    .out_data  (buf_data)
  );

  // Load FSM with counters, sticky return flag and registered status outputs.
  always_ff @(posedge clk or negedge crst_n) begin
    if (!crst_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      num_q        <= '0;
      acc_q        <= '0;
      tcnt_q       <= '0;
      flag_q       <= 1'b0;
      cfg_in_start <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      done         <= 1'b0;
      error        <= 1'b0;
      cfg_in_start <= 1'b0;
      if (busy && abort) begin
        state_q  <= StIdle;
        shreg_q  <= '0;
        flag_q   <= 1'b0;
        error    <= 1'b1;
        err_code <= ERR_ABORT;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              err_code <= ERR_NONE;
              if (num_words == '0) begin
                done <= 1'b1;
              end else begin
                num_q   <= num_words;
                acc_q   <= '0;
                state_q <= StFetch;
              end
            end
          end
          StFetch: begin
            if (word_valid) begin
              shreg_q      <= word_data;
              bit_cnt_q    <= '0;
              acc_q        <= acc_q + LEN_ONE;
              flag_q       <= 1'b0;
              tcnt_q       <= '0;
              cfg_in_start <= 1'b1;
              state_q      <= StShift;
            end
          end
          StShift: begin
            flag_q <= flag_now;
            if (buf_push && buf_ready) acc_q <= acc_q + LEN_ONE;
            if (last_bit) begin
              bit_cnt_q <= '0;
              if (buf_valid) begin
                shreg_q <= buf_data;
              end else begin
                shreg_q <= '0;
                if (words_left) begin
                  error    <= 1'b1;
                  err_code <= ERR_UNDERRUN;
                  state_q  <= StIdle;
                end else if (flag_now) begin
                  done    <= 1'b1;
                  state_q <= StIdle;
                end else begin
                  // Counter measures cycles since the last bit, which was this one.
                  tcnt_q  <= T_ONE;
                  state_q <= StDrain;
                end
              end
            end else begin
              shreg_q   <= {shreg_q[WORD_WIDTH-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
            end
          end
          StDrain: begin
            flag_q <= flag_now;
            if (flag_now) begin
              done    <= 1'b1;
              state_q <= StIdle;
            end else if (tcnt_q == T_MAX) begin
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
              state_q  <= StIdle;
            end else begin
              tcnt_q <= tcnt_q + T_ONE;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomized bench for cfg_chain_loader against a cycle-timeline reference model.
module tb_cfg_chain_loader;
  import cfg_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        crst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_words = '0;
  logic        abort = 1'b0;
  logic        word_valid = 1'b0;
  logic [15:0] word_data = '0;
  logic        cfg_out_start = 1'b0;
  logic        word_ready, cfg_in_start, cfg_bit_in, busy, done, error;
  logic [1:0]  err_code;

  int          n_total = 0;
  int          n_bad = 0;
  logic [15:0] wq [4];
  int          av [4];
  logic [1:0]  prev_code = ERR_NONE;

  always #5 clk = ~clk;

  cfg_chain_loader #(
    .WORD_WIDTH(16),
    .LEN_WIDTH (16),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .crst_n       (crst_n),
    .start        (start),
    .num_words    (num_words),
    .abort        (abort),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .cfg_in_start (cfg_in_start),
    .cfg_bit_in   (cfg_bit_in),
    .cfg_out_start(cfg_out_start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_ready"}, 32'(word_ready), 0);
    check_eq({tag, "_in_start"}, 32'(cfg_in_start), 0);
    check_eq({tag, "_bit"}, 32'(cfg_bit_in), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_error"}, 32'(error), 0);
    check_eq({tag, "_code"}, 32'(err_code), 0);
  endtask

  // One load of n words (wq/av preset). Cycle r=0 is the start cycle; av[] are host
  // availability cycles, lat is the chain return delay after the marker (<0: never),
  // ab is the abort cycle (<0: none). Entered and left just after a rising edge.
  task automatic run_load(input int n, input int lat, input int ab);
    int a0, s, m, l, nat_end, end_c, last_w, k, s_obs, ab_eff, hi;
    int e [4];
    int b [4];
    int acc [4];
    bit fail;
    logic [1:0] code;
    logic exp_ready, exp_bit, exp_start;
    logic [15:0] wtmp;

    for (int i = 0; i < 4; i++) begin
      e[i] = 0; b[i] = 0; acc[i] = 0;
    end
    fail = 1'b0; code = ERR_NONE; m = 0; last_w = 0; s = -1000; a0 = 0; nat_end = 1;
    if (n > 0) begin
      a0 = (av[0] > 1) ? av[0] : 1;
      s = a0 + 1;
      last_w = n - 1;
      for (int i = 1; i < n; i++) begin
        if (!fail) begin
          e[i] = s + W * (i - 1);
          b[i] = s + W * i - 1;
          acc[i] = (av[i] > e[i]) ? av[i] : e[i];
          // Next word must sit in the buffer before the boundary cycle.
          if (acc[i] > b[i] - 1) begin
            fail = 1'b1; nat_end = b[i] + 1; code = ERR_UNDERRUN; m = i; last_w = i;
          end
        end
      end
      if (!fail) begin
        l = s + W * n - 1;
        m = n;
        if (lat >= 0 && s + lat <= l + TO - 1) begin
          nat_end = ((l > s + lat) ? l : s + lat) + 1;
          code = ERR_NONE;
        end else begin
          nat_end = l + TO;
          code = ERR_TIMEOUT;
        end
      end
    end
    ab_eff = (n > 0 && ab >= 1 && ab <= nat_end - 1) ? ab : -1;
    end_c = nat_end;
    if (ab_eff >= 0) begin
      end_c = ab_eff + 1;
      code = ERR_ABORT;
    end

    k = 0; s_obs = -1;
    for (int r = 0; r <= end_c + 1; r++) begin
      start = (r == 0) || (r == ab_eff);
      num_words = 16'(n);
      abort = (r == ab_eff);
      word_valid = 1'b0;
      word_data = '0;
      if (k < n) begin
        if (r >= av[k]) begin
          word_valid = 1'b1;
          word_data = wq[k];
        end
      end
      cfg_out_start = (lat >= 0 && s_obs >= 0 && r == s_obs + lat);
      @(negedge clk);

      exp_ready = 1'b0;
      if (n > 0 && r < end_c) begin
        if (r >= 1 && r <= a0) exp_ready = 1'b1;
        for (int i = 1; i <= last_w; i++) begin
          hi = (acc[i] < b[i]) ? acc[i] : b[i];
          if (r >= e[i] && r <= hi) exp_ready = 1'b1;
        end
      end
      exp_start = (n > 0 && r == s && s < end_c);
      exp_bit = 1'b0;
      if (n > 0 && r >= s && r < s + W * m && r < end_c) begin
        wtmp = wq[(r - s) / W];
        exp_bit = wtmp[W - 1 - ((r - s) % W)];
      end
      check_eq("busy", 32'(busy), 32'(r >= 1 && r < end_c));
      check_eq("word_ready", 32'(word_ready), 32'(exp_ready));
      check_eq("cfg_in_start", 32'(cfg_in_start), 32'(exp_start));
      check_eq("cfg_bit_in", 32'(cfg_bit_in), 32'(exp_bit));
      check_eq("done", 32'(done), 32'(r == end_c && code == ERR_NONE));
      check_eq("error", 32'(error), 32'(r == end_c && code != ERR_NONE));
      check_eq("err_code", 32'(err_code),
               32'((r == 0) ? prev_code : ((r < end_c) ? ERR_NONE : code)));

      if (word_valid && word_ready) k++;
      if (cfg_in_start && s_obs < 0) s_obs = r;
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0; word_valid = 1'b0; cfg_out_start = 1'b0;
    prev_code = code;
  endtask

  initial begin
    int n, lat, ab, s0;

    #2 crst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 crst_n = 1'b1;

    // Three always-valid words, marker returns 56 cycles counting its own cycle.
    wq[0] = 16'hA5A5; wq[1] = 16'h0001; wq[2] = 16'hFFFF;
    av[0] = 0; av[1] = 0; av[2] = 0; av[3] = 0;
    run_load(3, 55, -1);

    // Second word withheld past the first word's last bit.
    wq[0] = 16'h8E17; wq[1] = 16'h1234;
    av[0] = 0; av[1] = 18;
    run_load(2, 5, -1);

    // Chain never answers.
    wq[0] = 16'hC3C3; av[0] = 0;
    run_load(1, -1, -1);

    // Abort (with start) in the 5th shift cycle.
    wq[0] = 16'hF0F0; wq[1] = 16'h0F0F; av[0] = 0; av[1] = 0;
    run_load(2, 10, 6);

    // Zero-length load.
    run_load(0, -1, -1);

    // Reset in the middle of shifting, then a clean single-word load.
    start = 1'b1; num_words = 16'd2; word_valid = 1'b1; word_data = 16'hFFFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pre_busy", 32'(busy), 1);
    check_eq("rst_pre_bit", 32'(cfg_bit_in), 1);
    #2 crst_n = 1'b0;
    word_valid = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(posedge clk);
    #1 crst_n = 1'b1;
    prev_code = ERR_NONE;
    wq[0] = 16'h3C5A; av[0] = 0;
    run_load(1, 3, -1);

    for (int t = 0; t < 40; t++) begin
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) wq[i] = 16'($urandom);
      av[0] = $urandom_range(0, 3);
      s0 = ((av[0] > 1) ? av[0] : 1) + 1;
      for (int i = 1; i < 4; i++) begin
        av[i] = s0 + W * (i - 1) +
                (($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 18))
                                               : int'($urandom_range(0, 9)));
      end
      lat = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, W * 4 + TO + 4));
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W * 4 + 8)) : -1;
      run_load(n, lat, ab);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
